guess_solver: RTL
=================

// Module: guess_solver
// PURPOSE
//  Machine-side guesser for the number game: the player holds the secret and
//  the block finds it by binary search. Each guess is presented on o_guess;
//  the player answers with over/under/equal buttons. Tracks tries left, and
//  flags win, loss (tries exhausted) and cheat (answers are inconsistent).
// PARAMETERS
//  WIDTH      8  secret/guess width; search range is 0 .. 2**WIDTH-1
//  MAX_TRIES  9  guesses allowed per game; 9 always suffices for WIDTH=8
//  TRY_W      4  width of o_tries_left; must hold MAX_TRIES
// PORTS
//  clk           in   1      single clock, rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  i_start       in   1      level; starts a new game from idle or a terminal state
//  i_over        in   1      level button: current guess > secret
//  i_under       in   1      level button: current guess < secret
//  i_equal       in   1      level button: current guess == secret
//  o_guess       out  WIDTH  current guess, registered
//  o_guess_valid out  1      high while the block waits for an answer
//  o_tries_left  out  TRY_W  guesses remaining, registered
//  o_busy        out  1      game in progress (not idle/terminal)
//  o_won         out  1      sticky until next start
//  o_lost        out  1      sticky until next start
//  o_cheat       out  1      sticky until next start
// BEHAVIOUR
//  - Reset (async assert, sync release): state S_IDLE; o_guess=0, valid=0,
//    tries_left=MAX_TRIES, busy/won/lost/cheat=0; lo=0, hi=2**WIDTH-1.
//  - States: S_IDLE, S_GUESS, S_WAIT_RESP, S_WAIT_RELEASE, S_UPDATE,
//    S_WON, S_LOST, S_CHEAT.
//  - S_IDLE/S_WON/S_LOST/S_CHEAT: i_start=1 -> lo=0, hi=max,
//    tries=MAX_TRIES, flags cleared, -> S_GUESS. i_start ignored elsewhere.
//  - S_GUESS (1 cycle): o_guess <= lo + ((hi-lo)>>1), tries_left decrements,
//    -> S_WAIT_RESP. o_guess updates on the clock edge that leaves S_GUESS,
//    i.e. one cycle after start or after S_UPDATE.
//  - S_WAIT_RESP: o_guess_valid=1. Response is accepted only when exactly one
//    of over/under/equal is high. It is latched into a resp register and the
//    FSM -> S_WAIT_RELEASE. With zero or more than one button high, the FSM
//    stays in S_WAIT_RESP and nothing changes.
//  - S_WAIT_RELEASE: valid=0; stays until all three buttons are low, then
//    -> S_UPDATE. One press means exactly one answer.
//  - S_UPDATE (1 cycle), applied in priority order:
//    - equal -> S_WON.
//    - over with guess==0, or under with guess==max -> S_CHEAT.
//    - over: hi=guess-1. under: lo=guess+1.
//    - If the new lo > new hi -> S_CHEAT.
//    - Else if tries_left==0 -> S_LOST.
//    - Else -> S_GUESS.
//  - lo/hi/mid arithmetic is done in WIDTH+1 bits; no wrap-around is possible.
//  - Terminal states: busy=0, valid=0, o_guess holds the last guess.
//  - Reset asserted mid-game aborts immediately to reset values.
// STRUCTURE
//  - Package guess_pkg: state_t enum and resp_t enum (R_OVER, R_UNDER,
//    R_EQUAL), plus a onehot3() helper function.
//  - One sub-module, search_range: holds lo/hi registers, computes mid, and
//    provides init/narrow_down/narrow_up strobes and a lo>hi flag.
//  - FSM and tries counter live in guess_solver.
// TESTING
//  1. Secret 200, honest answers -> guesses 127,191,223,207,199,203,201,200;
//     o_won=1, o_tries_left=1.
//  2. Secret 0 -> guesses 127,63,31,15,7,3,1,0; o_won=1 after 8 guesses.
//  3. Answer over to guess 0 (continue case 2 but press over) -> o_cheat=1,
//     busy=0.
//  4. MAX_TRIES=3, answer under three times -> guesses 127,191,223;
//     then o_lost=1, tries_left=0.
//  5. over+under pressed together in S_WAIT_RESP -> no transition, guess
//     stays 127. Button held 20 cycles -> exactly one update.
//  6. reset_n low while in S_WAIT_RESP -> all outputs at reset values next
//     sample. i_start after a win -> tries=MAX_TRIES, flags clear, guess 127.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types for the number-guessing solver.
//   state_t : solver FSM states
//   resp_t  : latched player answer
//   onehot3 : true when exactly one of three buttons is pressed
package guess_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GUESS,
      S_WAIT_RESP,
      S_WAIT_RELEASE,
      S_UPDATE,
      S_WON,
      S_LOST,
      S_CHEAT
   } state_t;

   typedef enum logic [1:0] {
      R_OVER,
      R_UNDER,
      R_EQUAL
   } resp_t;

   // Odd parity rules out 0 and 2 pressed; the AND term rules out all three.
   function automatic logic onehot3(input logic a, input logic b, input logic c);
      return (a ^ b ^ c) & ~(a & b & c);
   endfunction

endpackage

// File: rtl/search_range.sv
// Binary-search window [lo, hi] for the guess solver.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_init           reload full range 0 .. 2**WIDTH-1
//   i_narrow_down    guess was too high: hi = guess-1
//   i_narrow_up      guess was too low:  lo = guess+1
//   i_guess          guess the narrowing is relative to
//   o_mid            midpoint of the current window
//   o_cross          window after the pending update would be empty (lo > hi)
module search_range #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_init,
   input  logic             i_narrow_down,
   input  logic             i_narrow_up,
   input  logic [WIDTH-1:0] i_guess,
   output logic [WIDTH-1:0] o_mid,
   output logic             o_cross
);

   // One extra bit so guess+1 at the top and guess-1 at the bottom cannot wrap.
   localparam logic [WIDTH:0] MAX_V = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0] ONE_V = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] r_lo;
   logic [WIDTH:0] r_hi;
   logic [WIDTH:0] w_lo_nxt;
   logic [WIDTH:0] w_hi_nxt;

   always_comb begin
      w_lo_nxt = r_lo;
      w_hi_nxt = r_hi;
      if (i_init) begin
         w_lo_nxt = '0;
         w_hi_nxt = MAX_V;
      end else if (i_narrow_down) begin
         w_hi_nxt = {1'b0, i_guess} - ONE_V;
      end else if (i_narrow_up) begin
         w_lo_nxt = {1'b0, i_guess} + ONE_V;
      end
   end

   // Flag reflects the window as it will be after this cycle's update, so the
   // FSM can decide cheat in the same cycle it narrows.
   assign o_cross = (w_lo_nxt > w_hi_nxt);

   // While the window is non-empty, lo <= hi <= MAX_V, so the midpoint fits WIDTH bits.
   assign o_mid = WIDTH'(r_lo + ((r_hi - r_lo) >> 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo <= '0;
         r_hi <= MAX_V;
      end else begin
         r_lo <= w_lo_nxt;
         r_hi <= w_hi_nxt;
      end
   end

endmodule

// File: rtl/guess_solver.sv
// Machine-side binary-search guesser for the number game.
// The player holds the secret and answers each guess with over/under/equal.
//
//   state          | meaning
//   S_IDLE         | after reset, waiting for i_start
//   S_GUESS        | present midpoint, consume one try
//   S_WAIT_RESP    | guess valid, waiting for exactly one button
//   S_WAIT_RELEASE | answer latched, waiting for all buttons low
//   S_UPDATE       | apply answer, pick next state
//   S_WON          | equal received (terminal)
//   S_LOST         | tries exhausted (terminal)
//   S_CHEAT        | answers inconsistent (terminal)
//
// Ports:
//   clk, reset_n     clock, async active-low reset
//   i_start          start a new game from idle/terminal
//   i_over/i_under/i_equal  player answer buttons (levels)
//   o_guess, o_guess_valid  current guess and answer-wanted strobe
//   o_tries_left     guesses remaining
//   o_busy           game in progress
//   o_won/o_lost/o_cheat    sticky result flags
module guess_solver
   import guess_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_TRIES = 9,
   parameter int TRY_W     = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic             i_over,
   input  logic             i_under,
   input  logic             i_equal,
   output logic [WIDTH-1:0] o_guess,
   output logic             o_guess_valid,
   output logic [TRY_W-1:0] o_tries_left,
   output logic             o_busy,
   output logic             o_won,
   output logic             o_lost,
   output logic             o_cheat
);

   localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);

   state_t           r_state;
   resp_t            r_resp;
   logic [WIDTH-1:0] r_guess;
   logic             r_valid;
   logic [TRY_W-1:0] r_tries;
   logic             r_busy;
   logic             r_won;
   logic             r_lost;
   logic             r_cheat;

   logic             w_startable;
   logic             w_init;
   logic             w_edge_cheat;
   logic             w_narrow_down;
   logic             w_narrow_up;
   logic [WIDTH-1:0] w_mid;
   logic             w_cross;
   logic             w_any_btn;

   assign w_startable = (r_state == S_IDLE) || (r_state == S_WON) ||
                        (r_state == S_LOST) || (r_state == S_CHEAT);
   assign w_init      = w_startable && i_start;
   assign w_any_btn   = i_over | i_under | i_equal;

   // Answers that would push the window outside 0..max are caught before
   // narrowing so the range registers never see an out-of-range bound.
   assign w_edge_cheat  = ((r_resp == R_OVER)  && (r_guess == '0)) ||
                          ((r_resp == R_UNDER) && (&r_guess));
   assign w_narrow_down = (r_state == S_UPDATE) && (r_resp == R_OVER)  && !w_edge_cheat;
   assign w_narrow_up   = (r_state == S_UPDATE) && (r_resp == R_UNDER) && !w_edge_cheat;

   search_range #(
      .WIDTH (WIDTH)
   ) u_range (
      .clk           (clk),
      .rst_n         (reset_n),
      .i_init        (w_init),
      .i_narrow_down (w_narrow_down),
      .i_narrow_up   (w_narrow_up),
      .i_guess       (r_guess),
      .o_mid         (w_mid),
      .o_cross       (w_cross)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_resp  <= R_OVER;
         r_guess <= '0;
         r_valid <= 1'b0;
         r_tries <= TRIES_INIT;
         r_busy  <= 1'b0;
         r_won   <= 1'b0;
         r_lost  <= 1'b0;
         r_cheat <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_WON, S_LOST, S_CHEAT: begin
               if (i_start) begin
                  r_tries <= TRIES_INIT;
                  r_won   <= 1'b0;
                  r_lost  <= 1'b0;
                  r_cheat <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_GUESS;
               end
            end
            S_GUESS: begin
               r_guess <= w_mid;
               r_tries <= r_tries - 1'b1;
               r_valid <= 1'b1;
               r_state <= S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
               if (onehot3(i_over, i_under, i_equal)) begin
                  if (i_over) begin
                     r_resp <= R_OVER;
                  end else if (i_under) begin
                     r_resp <= R_UNDER;
                  end else begin
                     r_resp <= R_EQUAL;
                  end
                  r_valid <= 1'b0;
                  r_state <= S_WAIT_RELEASE;
               end
            end
            S_WAIT_RELEASE: begin
               if (!w_any_btn) begin
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (r_resp == R_EQUAL) begin
                  r_won   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_WON;
               end else if (w_edge_cheat || w_cross) begin
                  r_cheat <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_CHEAT;
               end else if (r_tries == '0) begin
                  r_lost  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_LOST;
               end else begin
                  r_state <= S_GUESS;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_guess       = r_guess;
   assign o_guess_valid = r_valid;
   assign o_tries_left  = r_tries;
   assign o_busy        = r_busy;
   assign o_won         = r_won;
   assign o_lost        = r_lost;
   assign o_cheat       = r_cheat;

endmodule
